dump_ctrl: RTL and testbench
============================

Name: dump_ctrl

Overview:
Sequences a channel dump for the capture path. On a dump request it fetches that channel's offset and gain calibration bytes from the calibration EEPROM over the shared SPI master, strobing them into the gain-correction registers. It then walks the circular capture RAM from the oldest sample and pushes every corrected sample out the UART response path, one byte per send_resp/resp_sent handshake. It sits beside the command decoder, which forwards dump/dump_ch. The top level gives dump_ctrl the SPI master and the send_resp path while busy=1.

Parameters:
DEPTH, 512, capture RAM depth in samples; must be a power of two.
AW, 9, RAM address width, log2(DEPTH).
EEP_SS, 3'b100, slave-select code of the calibration EEPROM.
DUMMY_WORD, 16'hBCBC, SPI word sent to clock out EEPROM read data.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active high
dump  in  1  one-cycle dump request
dump_ch  in  2  channel to dump: 00=ch1, 01=ch2, 10=ch3, 11=reserved
ch1_AFEgain  in  3  current AFE gain setting, channel 1
ch2_AFEgain  in  3  current AFE gain setting, channel 2
ch3_AFEgain  in  3  current AFE gain setting, channel 3
start_addr  in  AW  RAM address of the oldest captured sample (write pointer at capture end)
SPI_done  in  1  SPI transaction complete; EEP_data valid in the same cycle
wrt_SPI  out  1  start an SPI transaction
ss  out  3  slave select for the SPI master
SPI_data  out  16  SPI word to transmit
flopOffset  out  1  capture EEP_data as offset
flopGain  out  1  capture EEP_data as gain
ram_addr  out  AW  capture RAM read address
ren  out  1  RAM read enable; 1-cycle synchronous read latency
send_resp  out  1  corrected byte is valid; start UART transmit
resp_sent  in  1  UART transmit complete
busy  out  1  dump in progress; owns the SPI and UART paths
dump_done  out  1  one-cycle pulse when the last sample has been sent
dump_err  out  1  one-cycle pulse when a dump request is rejected

Behaviour:
- Single clock. All state updates on posedge clk. rst is synchronous and active high.
- Reset values: state IDLE, all outputs 0, ss=EEP_SS, SPI_data=0, ram_addr=0. The internal pointer and counter are 0.
- EEPROM address (6 bits) = {ch[1:0], gain[2:0], sel}, where sel=0 for offset and sel=1 for gain.
  - gain is the selected channel's AFE gain value, latched at the request.
  - EEPROM read command word = {2'b00, addr[5:0], 8'h00}.
- States and transitions:
  - IDLE:
    - On dump=1 with dump_ch!=11: latch ch, gain, and ptr=start_addr; clear cnt; go to OFF_CMD.
    - On dump=1 with dump_ch=11: pulse dump_err and stay in IDLE.
  - OFF_CMD: send the offset read command; on SPI_done go to OFF_RD.
  - OFF_RD: send DUMMY_WORD; on SPI_done assert flopOffset for that cycle and go to GAIN_CMD.
  - GAIN_CMD: send the gain read command; on SPI_done go to GAIN_RD.
  - GAIN_RD: send DUMMY_WORD; on SPI_done assert flopGain for that cycle and go to RAM_RD.
  - RAM_RD: ren=1 and ram_addr=ptr for exactly one cycle; go to SEND.
  - SEND: send_resp=1 for exactly one cycle, since RAM data is valid this cycle; go to WAIT_TX.
  - WAIT_TX: wait for resp_sent.
    - If cnt==DEPTH-1, go to DONE.
    - Otherwise ptr=ptr+1 modulo DEPTH (DEPTH-1 wraps to 0), cnt=cnt+1, go to RAM_RD.
  - DONE: dump_done=1 for one cycle; go to IDLE.
- SPI state rules:
  - wrt_SPI is high only on the first cycle of each SPI state.
  - ss=EEP_SS and SPI_data are held constant for the whole state.
  - SPI_done in the same cycle as wrt_SPI is ignored.
- resp_sent is sampled only in WAIT_TX and ignored elsewhere.
- busy=1 in every state except IDLE.
- A dump asserted while busy is ignored: no dump_err and no effect on the current dump.
- Each dump emits exactly DEPTH send_resp pulses, covering addresses start_addr..start_addr+DEPTH-1 modulo DEPTH, in order.
- rst asserted mid-dump returns to IDLE on the next edge. No further pulses are emitted. Outputs take their reset values.
- A stalled SPI_done or resp_sent holds the FSM indefinitely; there is no timeout.

Decomposition:
- Shared package (scope_pkg) holds:
  - the state_t enum;
  - EEP_SS, DUMMY_WORD, and the EEPROM read opcode 2'b00;
  - the channel codes;
  - the helper that builds the EEPROM address.
- Optional sub-module dump_addr_gen holds the AW-bit wrapping pointer and the sample counter with a last flag. The FSM stays in dump_ctrl.

Test Plan:
- dump_ch=01, ch2_AFEgain=3'b101 -> SPI words 16'h1A00, 16'hBCBC, 16'h1B00, 16'hBCBC in order, all with ss=100. flopOffset and flopGain each pulse once, on the 2nd and 4th SPI_done.
- start_addr=9'h1F0, UART model returns resp_sent 3 cycles after send_resp -> 512 send_resp pulses. ram_addr sequence is 1F0..1FF, 000..1EF. dump_done is one cycle, after the final resp_sent.
- dump_ch=11 -> dump_err pulses once. No wrt_SPI, ren, or send_resp; busy stays 0.
- Second dump pulse during the RAM walk -> ignored; the transfer is unchanged at 512 samples.
- rst asserted while in WAIT_TX on sample 100 -> next cycle busy=0 with all outputs at reset values. A new dump then restarts from the offset read.
- SPI_done withheld for 50 cycles in OFF_CMD -> wrt_SPI pulsed once only, state holds, SPI_data stable until SPI_done arrives.

Source files
------------

// File: rtl/scope_pkg.sv
// scope_pkg: definitions shared by the dump controller and its helpers.
//   state_t      - dump sequencer states
//   EEP_SS       - slave-select code of the calibration EEPROM
//   DUMMY_WORD   - SPI word used to clock out EEPROM read data
//   EEP_RD_OP    - EEPROM read opcode (top two bits of the command word)
//   CH1..CH_RSVD - dump channel codes
//   eep_addr()   - builds the 6-bit calibration address {ch, gain, sel}
//   eep_rd_cmd() - builds the 16-bit EEPROM read command word
package scope_pkg;

    typedef enum logic [3:0] {
        IDLE,
        OFF_CMD,
        OFF_RD,
        GAIN_CMD,
        GAIN_RD,
        RAM_RD,
        SEND,
        WAIT_TX,
        DONE
    } state_t;

    localparam logic [2:0]  EEP_SS     = 3'b100;
    localparam logic [15:0] DUMMY_WORD = 16'hBCBC;
    localparam logic [1:0]  EEP_RD_OP  = 2'b00;

    localparam logic [1:0] CH1     = 2'b00;
    localparam logic [1:0] CH2     = 2'b01;
    localparam logic [1:0] CH3     = 2'b10;
    localparam logic [1:0] CH_RSVD = 2'b11;

    // sel = 0 selects the offset byte, sel = 1 the gain byte.
    function automatic logic [5:0] eep_addr(input logic [1:0] ch,
                                            input logic [2:0] gain,
                                            input logic       sel);
        return {ch, gain, sel};
    endfunction

    function automatic logic [15:0] eep_rd_cmd(input logic [5:0] addr);
        return {EEP_RD_OP, addr, 8'h00};
    endfunction

endpackage

// File: rtl/dump_ctrl_if.sv
// dump_ctrl_if: SPI master, capture RAM read and UART response signals used
// by the dump sequencer.
//   wrt_SPI/ss/SPI_data/SPI_done - SPI transaction start, select, word, done
//   ram_addr/ren                 - capture RAM read (1-cycle read latency)
//   send_resp/resp_sent          - UART byte send request / completion
// Handshakes: a request (wrt_SPI, send_resp) is a one-cycle strobe from the
// master; the matching completion (SPI_done, resp_sent) is a one-cycle
// strobe from the slave that may arrive any number of cycles later. The
// master holds ss and SPI_data stable until the completion arrives and
// issues no new request on that path before it.
interface dump_ctrl_if #(parameter int AW = 9) ();
    logic          wrt_SPI;
    logic [2:0]    ss;
    logic [15:0]   SPI_data;
    logic          SPI_done;
    logic [AW-1:0] ram_addr;
    logic          ren;
    logic          send_resp;
    logic          resp_sent;

    modport master (
        output wrt_SPI, ss, SPI_data, ram_addr, ren, send_resp,
        input  SPI_done, resp_sent
    );

    modport slave (
        input  wrt_SPI, ss, SPI_data, ram_addr, ren, send_resp,
        output SPI_done, resp_sent
    );
endinterface

// File: rtl/dump_addr_gen.sv
// dump_addr_gen: wrapping capture-RAM read pointer and sample counter.
//   clk, rst   - clock, synchronous active-high reset
//   load       - ptr <= start_addr, cnt <= 0
//   start_addr - oldest sample address
//   advance    - step to the next sample (ptr wraps modulo DEPTH)
//   ptr        - current read address
//   last       - current sample is the final one of the dump
module dump_addr_gen #(
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [AW-1:0] start_addr,
    input  logic          advance,
    output logic [AW-1:0] ptr,
    output logic          last
);
    logic [AW-1:0] cnt;

    // DEPTH is 2**AW, so the natural AW-bit rollover is the wrap to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
            cnt <= '0;
        end else if (load) begin
            ptr <= start_addr;
            cnt <= '0;
        end else if (advance) begin
            ptr <= ptr + AW'(1);
            cnt <= cnt + AW'(1);
        end
    end

    assign last = (cnt == AW'(DEPTH - 1));
endmodule

// File: rtl/dump_ctrl.sv
// dump_ctrl: channel dump sequencer. Reads the offset and gain calibration
// bytes of the requested channel from the EEPROM over SPI, then streams all
// DEPTH capture samples, oldest first, out the UART response path.
//   clk, rst        - clock, synchronous active-high reset
//   dump, dump_ch   - one-cycle dump request and channel (11 = reserved)
//   chN_AFEgain     - current AFE gain per channel, latched at the request
//   start_addr      - address of the oldest captured sample
//   flopOffset/Gain - strobe EEPROM read data into the correction registers
//   busy            - dump in progress (owns SPI and UART paths)
//   dump_done       - one-cycle pulse after the last sample is sent
//   dump_err        - one-cycle pulse when a request is rejected
//   dbg_state       - current sequencer state
//   bus             - SPI / RAM / UART signals
module dump_ctrl
    import scope_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dump,
    input  logic [1:0]    dump_ch,
    input  logic [2:0]    ch1_AFEgain,
    input  logic [2:0]    ch2_AFEgain,
    input  logic [2:0]    ch3_AFEgain,
    input  logic [AW-1:0] start_addr,
    output logic          flopOffset,
    output logic          flopGain,
    output logic          busy,
    output logic          dump_done,
    output logic          dump_err,
    output state_t        dbg_state,
    dump_ctrl_if.master   bus
);
    state_t        state, state_n;
    logic [1:0]    ch_q;
    logic [2:0]    gain_q;
    logic [2:0]    gain_sel;
    logic          spi_started;
    logic          spi_ack;
    logic          load, advance;
    logic [AW-1:0] ptr;
    logic          last;

    dump_addr_gen #(.DEPTH(DEPTH), .AW(AW)) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .start_addr (start_addr),
        .advance    (advance),
        .ptr        (ptr),
        .last       (last)
    );

    always_comb begin
        gain_sel = ch1_AFEgain;
        case (dump_ch)
            CH2:     gain_sel = ch2_AFEgain;
            CH3:     gain_sel = ch3_AFEgain;
            default: gain_sel = ch1_AFEgain;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Low on the first cycle of every state: that cycle issues wrt_SPI and
    // an SPI_done seen alongside it is not yet the answer to this request.
    always_ff @(posedge clk) begin
        if (rst || (state_n != state)) begin
            spi_started <= 1'b0;
        end else begin
            spi_started <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ch_q   <= '0;
            gain_q <= '0;
        end else if (load) begin
            ch_q   <= dump_ch;
            gain_q <= gain_sel;
        end
    end

    assign spi_ack   = spi_started && bus.SPI_done;
    assign dbg_state = state;

    always_comb begin
        state_n       = state;
        load          = 1'b0;
        advance       = 1'b0;
        bus.wrt_SPI   = 1'b0;
        bus.ss        = EEP_SS;
        bus.SPI_data  = 16'h0000;
        bus.ram_addr  = '0;
        bus.ren       = 1'b0;
        bus.send_resp = 1'b0;
        flopOffset    = 1'b0;
        flopGain      = 1'b0;
        dump_done     = 1'b0;
        dump_err      = 1'b0;
        busy          = (state != IDLE);
        case (state)
            IDLE: begin
                if (dump) begin
                    if (dump_ch == CH_RSVD) begin
                        dump_err = 1'b1;
                    end else begin
                        load    = 1'b1;
                        state_n = OFF_CMD;
                    end
                end
            end
            OFF_CMD: begin
                bus.SPI_data = eep_rd_cmd(eep_addr(ch_q, gain_q, 1'b0));
                bus.wrt_SPI  = !spi_started;
                if (spi_ack) state_n = OFF_RD;
            end
            OFF_RD: begin
                bus.SPI_data = DUMMY_WORD;
                bus.wrt_SPI  = !spi_started;
                if (spi_ack) begin
                    flopOffset = 1'b1;
                    state_n    = GAIN_CMD;
                end
            end
            GAIN_CMD: begin
                bus.SPI_data = eep_rd_cmd(eep_addr(ch_q, gain_q, 1'b1));
                bus.wrt_SPI  = !spi_started;
                if (spi_ack) state_n = GAIN_RD;
            end
            GAIN_RD: begin
                bus.SPI_data = DUMMY_WORD;
                bus.wrt_SPI  = !spi_started;
                if (spi_ack) begin
                    flopGain = 1'b1;
                    state_n  = RAM_RD;
                end
            end
            RAM_RD: begin
                bus.ren      = 1'b1;
                bus.ram_addr = ptr;
                state_n      = SEND;
            end
            SEND: begin
                // RAM data from the previous cycle's read is valid now.
                bus.send_resp = 1'b1;
                state_n       = WAIT_TX;
            end
            WAIT_TX: begin
                if (bus.resp_sent) begin
                    if (last) begin
                        state_n = DONE;
                    end else begin
                        advance = 1'b1;
                        state_n = RAM_RD;
                    end
                end
            end
            DONE: begin
                dump_done = 1'b1;
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_dump_ctrl.sv
// tb_dump_ctrl: randomized bench for dump_ctrl with a behavioural model of
// the expected SPI words, RAM addresses and handshake pulses.
module tb_dump_ctrl;
    import scope_pkg::*;

    localparam int DEPTH = 512;
    localparam int AW    = 9;

    // ---------------- clock / reset / signals ----------------
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          dump = 1'b0;
    logic [1:0]    dump_ch = 2'b00;
    logic [2:0]    g1 = 3'd0, g2 = 3'd0, g3 = 3'd0;
    logic [AW-1:0] start_addr = '0;
    logic          flopOffset, flopGain, busy, dump_done, dump_err;
    state_t        dbg_state;

    dump_ctrl_if #(.AW(AW)) bus ();

    dump_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .dump        (dump),
        .dump_ch     (dump_ch),
        .ch1_AFEgain (g1),
        .ch2_AFEgain (g2),
        .ch3_AFEgain (g3),
        .start_addr  (start_addr),
        .flopOffset  (flopOffset),
        .flopGain    (flopGain),
        .busy        (busy),
        .dump_done   (dump_done),
        .dump_err    (dump_err),
        .dbg_state   (dbg_state),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard / model state ----------------
    logic [15:0]   exp_spi_q[$];
    logic [AW-1:0] exp_q[$];
    logic [15:0]   obs_spi[$];
    logic [AW-1:0] obs_addr[$];
    int   m_busy = 0, m_done_next = 0, m_sent = 0, m_acked = 0, m_wrt = 0;
    int   done_cnt = 0, err_cnt = 0, fo_cnt = 0, fg_cnt = 0;
    int   spi_done_idx = 0;
    int   spi_delay_first = 0;
    int   uart_delay = 0;
    logic spi_open = 1'b0;
    logic [15:0] cur_word = '0;
    logic prev_ren = 1'b0, prev_resp = 1'b0;

    // ---------------- SPI slave responder ----------------
    initial begin
        int d;
        bus.SPI_done = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.wrt_SPI === 1'b1 && !rst) begin
                d = (spi_delay_first > 0) ? spi_delay_first : int'($urandom_range(1, 4));
                spi_delay_first = 0;
                repeat (d) @(posedge clk);
                #1;
                bus.SPI_done = 1'b1;
                spi_done_idx++;
                @(posedge clk);
                #1;
                bus.SPI_done = 1'b0;
            end
        end
    end

    // ---------------- UART responder ----------------
    initial begin
        int d;
        bus.resp_sent = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.send_resp === 1'b1 && !rst) begin
                d = (uart_delay > 0) ? uart_delay : int'($urandom_range(1, 5));
                repeat (d) @(posedge clk);
                #1;
                bus.resp_sent = 1'b1;
                @(posedge clk);
                #1;
                bus.resp_sent = 1'b0;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        logic accept;
        logic [2:0] g;
        logic [31:0] w;
        if (rst) begin
            m_busy = 0; m_done_next = 0; m_sent = 0; m_acked = 0;
            exp_spi_q.delete(); exp_q.delete();
            spi_open = 1'b0; prev_ren = 1'b0; prev_resp = 1'b0;
        end else begin
            check("busy", busy, m_busy != 0);
            check("dump_done", dump_done, m_done_next != 0);
            check("dump_err", dump_err, dump && (m_busy == 0) && (dump_ch == 2'b11));
            check("flopOffset", flopOffset, bus.SPI_done && (m_busy != 0) && (spi_done_idx == 2));
            check("flopGain", flopGain, bus.SPI_done && (m_busy != 0) && (spi_done_idx == 4));
            if (dump_err) err_cnt++;
            if (flopOffset) fo_cnt++;
            if (flopGain) fg_cnt++;

            if (bus.wrt_SPI) begin
                check("spi_expected", exp_spi_q.size() != 0, 1);
                if (exp_spi_q.size() != 0) check("spi_word", bus.SPI_data, exp_spi_q.pop_front());
                check("spi_ss", bus.ss, 3'b100);
                obs_spi.push_back(bus.SPI_data);
                spi_open = 1'b1;
                cur_word = bus.SPI_data;
                m_wrt++;
            end else if (spi_open) begin
                check("spi_hold", bus.SPI_data, cur_word);
                check("spi_ss_hold", bus.ss, 3'b100);
            end
            if (bus.SPI_done) spi_open = 1'b0;

            if (bus.ren) begin
                check("ren_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("ram_addr", bus.ram_addr, exp_q.pop_front());
                obs_addr.push_back(bus.ram_addr);
            end
            if (bus.send_resp) begin
                check("send_after_ren", prev_ren, 1);
                m_sent++;
            end

            if (m_done_next != 0) begin
                check("sample_count", m_sent, DEPTH);
                check("wrt_count", m_wrt, 4);
                check("addr_q_empty", exp_q.size(), 0);
                check("done_after_resp", prev_resp, 1);
                done_cnt++;
            end

            // model update
            accept = dump && (m_busy == 0) && (dump_ch != 2'b11);
            if (m_done_next != 0) begin
                m_busy = 0;
                m_done_next = 0;
            end else if ((m_busy != 0) && bus.resp_sent && (m_acked < m_sent)) begin
                m_acked++;
                if (m_acked == DEPTH) m_done_next = 1;
            end
            if (accept) begin
                g = (dump_ch == 2'b00) ? g1 : (dump_ch == 2'b01) ? g2 : g3;
                exp_spi_q.delete(); exp_q.delete();
                obs_spi.delete(); obs_addr.delete();
                for (int sel = 0; sel < 2; sel++) begin
                    w = (32'(dump_ch) * 16 + 32'(g) * 2 + 32'(sel)) * 256;
                    exp_spi_q.push_back(w[15:0]);
                    exp_spi_q.push_back(16'hBCBC);
                end
                for (int i = 0; i < DEPTH; i++) begin
                    w = (32'(start_addr) + 32'(i)) % DEPTH;
                    exp_q.push_back(w[AW-1:0]);
                end
                spi_done_idx = 0;
                m_busy = 1; m_sent = 0; m_acked = 0; m_wrt = 0;
                fo_cnt = 0; fg_cnt = 0;
            end
            prev_ren  = bus.ren;
            prev_resp = bus.resp_sent;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_dump(input logic [1:0] ch);
        @(posedge clk);
        #1;
        dump    = 1'b1;
        dump_ch = ch;
        @(posedge clk);
        #1;
        dump    = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int start;
        start = done_cnt;
        for (int i = 0; i < budget && done_cnt == start; i++) @(posedge clk);
        check("done_timeout", done_cnt != start, 1);
    endtask

    task automatic wait_sent(input int n, input int budget);
        for (int i = 0; i < budget && m_sent < n; i++) @(posedge clk);
        check("sent_timeout", m_sent >= n, 1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_wrt_SPI"}, bus.wrt_SPI, 0);
        check({tag, "_ss"}, bus.ss, 3'b100);
        check({tag, "_SPI_data"}, bus.SPI_data, 0);
        check({tag, "_ram_addr"}, bus.ram_addr, 0);
        check({tag, "_ren"}, bus.ren, 0);
        check({tag, "_send_resp"}, bus.send_resp, 0);
        check({tag, "_flops"}, {flopOffset, flopGain}, 0);
        check({tag, "_done_err"}, {dump_done, dump_err}, 0);
        check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("reset");

        // channel 2 dump, gain 5, wrapping start, fixed UART latency
        g1 = 3'b010; g2 = 3'b101; g3 = 3'b111;
        start_addr = 9'h1F0;
        uart_delay = 3;
        do_dump(2'b01);
        wait_done(8000);
        check("lit_spi0", obs_spi[0], 16'h1A00);
        check("lit_spi1", obs_spi[1], 16'hBCBC);
        check("lit_spi2", obs_spi[2], 16'h1B00);
        check("lit_spi3", obs_spi[3], 16'hBCBC);
        check("lit_addr_n", obs_addr.size(), 512);
        check("lit_addr0", obs_addr[0], 9'h1F0);
        check("lit_addr15", obs_addr[15], 9'h1FF);
        check("lit_addr16", obs_addr[16], 9'h000);
        check("lit_addr511", obs_addr[511], 9'h1EF);
        check("lit_fo_cnt", fo_cnt, 1);
        check("lit_fg_cnt", fg_cnt, 1);

        // reserved channel is rejected
        err_cnt = 0;
        do_dump(2'b11);
        repeat (10) @(posedge clk);
        check("err_pulses", err_cnt, 1);

        // second request during the RAM walk is ignored
        uart_delay = 0;
        g1 = 3'($urandom); g2 = 3'($urandom); g3 = 3'($urandom);
        start_addr = AW'($urandom);
        do_dump(2'b00);
        wait_sent(200, 4000);
        do_dump(2'b10);
        wait_done(8000);

        // reset while waiting on sample 100, then a fresh dump
        uart_delay = 3;
        start_addr = AW'($urandom);
        do_dump(2'b10);
        wait_sent(100, 4000);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("mid_reset");
        repeat (10) @(posedge clk);
        g3 = 3'($urandom);
        do_dump(2'b10);
        wait_done(8000);
        check("restart_offset_cmd", obs_spi[0], {2'b00, 2'b10, g3, 1'b0, 8'h00});

        // long SPI stall on the offset command
        spi_delay_first = 50;
        uart_delay = 0;
        g1 = 3'($urandom); g2 = 3'($urandom);
        start_addr = AW'($urandom);
        do_dump(2'($urandom_range(0, 2)));
        wait_done(8000);
        check("stall_fo_cnt", fo_cnt, 1);

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
